pool_sched: RTL

POOL_SCHED -- requirements
Module: pool_sched

---
 rtl/pool_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pool_sched.sv
// Purpose: round-robin scheduler sharing one 2x2 averaging engine among N_REQ pooling requesters.
// Latency: req sampled in IDLE at cycle 0, gnt at cycle 1, resp_valid at cycle 6+ENG_LAT.
// Backpressure: none; a requester holds req until its gnt pulse, the response is a single-cycle pulse.
//
// Ports: clk/rst (async active-low); req/win_data from requesters; gnt per requester;
//        resp_valid/resp_id/resp_data response; busy status; eng_rst/eng_en/eng_din/eng_avg engine side.
module pool_sched #(
    parameter int N_REQ   = 4,
    parameter int ENG_LAT = 3,
    localparam int IW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*128-1:0]     win_data,
    output logic [N_REQ-1:0]         gnt,
    output logic                     resp_valid,
    output logic [IW-1:0]            resp_id,
    output logic signed [31:0]       resp_data,
    output logic                     busy,
    output logic                     eng_rst,
    output logic                     eng_en,
    output logic signed [31:0]       eng_din,
    input  logic signed [31:0]       eng_avg
);

    typedef enum logic [2:0] {IDLE, CLR, FEED, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  id_q, id_d;
    logic [127:0]   win_q, win_d;

    logic [N_REQ-1:0]   gnt_d;
    logic               resp_valid_d;
    logic [IW-1:0]      resp_id_d;
    logic signed [31:0] resp_data_d;
    logic               busy_d;
    logic               eng_rst_d;
    logic               eng_en_d;
    logic signed [31:0] eng_din_d;

    logic               found;
    logic [IW-1:0]      pick;

    // Every output is computed one cycle ahead from the next state and then
    // registered, so the pins never see decode glitches.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        win_d        = win_q;
        gnt_d        = '0;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id;
        resp_data_d  = resp_data;
        eng_rst_d    = 1'b0;
        eng_en_d     = 1'b0;
        eng_din_d    = eng_din;
        found        = 1'b0;
        pick         = '0;

        // Round-robin scan starting just after the last granted requester.
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[(int'(ptr_q) + k) % N_REQ]) begin
                found = 1'b1;
                pick  = IW'((int'(ptr_q) + k) % N_REQ);
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = CLR;
                    gnt_d[pick] = 1'b1;
                    id_d        = pick;
                    win_d       = win_data[int'(pick)*128 +: 128];
                    ptr_d       = (pick == IW'(N_REQ - 1)) ? '0 : pick + IW'(1);
                    eng_rst_d   = 1'b1;
                end
            end
            CLR: begin
                // First operand goes out as we enter FEED; cnt indexes the next one.
                state_d   = FEED;
                eng_en_d  = 1'b1;
                eng_din_d = win_q[31:0];
                cnt_d     = 8'd1;
            end
            FEED: begin
                if (cnt_q == 8'd4) begin
                    state_d = WAIT;
                    cnt_d   = 8'd0;
                end else begin
                    eng_en_d  = 1'b1;
                    eng_din_d = win_q[{cnt_q[1:0], 5'b0} +: 32];
                    cnt_d     = cnt_q + 8'd1;
                end
            end
            WAIT: begin
                if (cnt_q == 8'(ENG_LAT - 1)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_data_d  = eng_avg;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            id_q       <= '0;
            win_q      <= '0;
            gnt        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
            busy       <= 1'b0;
            eng_rst    <= 1'b1;
            eng_en     <= 1'b0;
            eng_din    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            win_q      <= win_d;
            gnt        <= gnt_d;
            resp_valid <= resp_valid_d;
            resp_id    <= resp_id_d;
            resp_data  <= resp_data_d;
            busy       <= busy_d;
            eng_rst    <= eng_rst_d;
            eng_en     <= eng_en_d;
            eng_din    <= eng_din_d;
        end
    end

endmodule
